// File: rtl/agdc_input_cond.sv
// agdc_input_cond: sync + debounce for the wall button and both door limit
// switches, driving AGDC Activate / UP_Max / DN_Max and a both-limits fault.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset, clears every flop
//   btn_raw    - raw wall button (1 = pressed)
//   up_lim_raw - raw upper limit switch (1 = door fully open)
//   dn_lim_raw - raw lower limit switch (1 = door fully closed)
//   Activate   - one-cycle press pulse, gated by holdoff and limit fault
//   UP_Max     - debounced upper limit level
//   DN_Max     - debounced lower limit level
//   lim_fault  - high while both debounced limits are high
module agdc_input_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int HOLDOFF     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic up_lim_raw,
    input  logic dn_lim_raw,
    output logic Activate,
    output logic UP_Max,
    output logic DN_Max,
    output logic lim_fault
);

    localparam int NCH = 3;
    localparam int CW  = $clog2(DEB_CYCLES + 1);
    // A zero holdoff still gets a 1-bit counter that simply never loads.
    localparam int HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

    // Channel index: 0 = button, 1 = up limit, 2 = down limit.
    localparam int CH_BTN = 0;
    localparam int CH_UP  = 1;
    localparam int CH_DN  = 2;

    logic [NCH-1:0]         w_raw;
    logic [SYNC_STAGES-1:0] r_sync    [NCH];
    logic [NCH-1:0]         w_sync;
    logic [NCH-1:0]         r_deb;
    logic [NCH-1:0]         w_deb_nxt;
    logic [CW-1:0]          r_cnt     [NCH];
    logic [CW-1:0]          w_cnt_nxt [NCH];
    logic [HW-1:0]          r_hold;
    logic [HW-1:0]          w_hold_nxt;
    logic                   r_act;
    logic                   r_fault;
    logic                   w_fault_nxt;
    logic                   w_press;
    logic                   w_fire;

    assign w_raw = {dn_lim_raw, up_lim_raw, btn_raw};

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
            end
        end
    end

    always_comb begin
        w_sync = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sync[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Debounce: level flips only after DEB_CYCLES consecutive
    // disagreeing cycles; any agreeing cycle restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        w_deb_nxt = r_deb;
        for (int i = 0; i < NCH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_sync[i] != r_deb[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_deb_nxt[i] = w_sync[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb <= w_deb_nxt;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault and press qualification. Both use next-state debounced
    // levels so they line up with UP_Max / DN_Max on the same edge.
    // ------------------------------------------------------------------
    assign w_fault_nxt = w_deb_nxt[CH_UP] & w_deb_nxt[CH_DN];
    assign w_press     = w_deb_nxt[CH_BTN] & ~r_deb[CH_BTN];
    // Disqualified presses are dropped, never queued.
    assign w_fire      = w_press & (r_hold == '0) & ~w_fault_nxt;

    always_comb begin
        w_hold_nxt = r_hold;
        if (w_fire) begin
            w_hold_nxt = HOLD_LOAD;
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act   <= 1'b0;
            r_fault <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_act   <= w_fire;
            r_fault <= w_fault_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign Activate  = r_act;
    assign UP_Max    = r_deb[CH_UP];
    assign DN_Max    = r_deb[CH_DN];
    assign lim_fault = r_fault;

endmodule

// File: tb/tb_agdc_input_cond.sv
// tb_agdc_input_cond: table vectors, hand sequences and random stimulus
// against a cycle-counting reference model, for HOLDOFF=16 and HOLDOFF=0.
module tb_agdc_input_cond;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int HO = 16;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic up_lim_raw;
    logic dn_lim_raw;
    logic act_a, up_a, dn_a, f_a;
    logic act_b, up_b, dn_b, f_b;

    always #5 clk = ~clk;

    agdc_input_cond #(
        .SYNC_STAGES(SS), .DEB_CYCLES(DC), .HOLDOFF(HO)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .up_lim_raw(up_lim_raw), .dn_lim_raw(dn_lim_raw),
        .Activate(act_a), .UP_Max(up_a), .DN_Max(dn_a), .lim_fault(f_a)
    );

    agdc_input_cond #(
        .SYNC_STAGES(SS), .DEB_CYCLES(DC), .HOLDOFF(0)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .up_lim_raw(up_lim_raw), .dn_lim_raw(dn_lim_raw),
        .Activate(act_b), .UP_Max(up_b), .DN_Max(dn_b), .lim_fault(f_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pa = 0;
    int pb = 0;

    // Reference model: raw samples delayed SS edges; a level flips after
    // DC consecutive disagreeing samples; holdoff measured as edges since
    // the last accepted pulse.
    logic [2:0] m_hist [$];
    logic [2:0] m_deb;
    int         m_run [3];
    int         m_cyc;
    int         m_last [2];
    logic       m_act [2];
    logic       m_fault;

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < SS; i++) m_hist.push_back(3'b000);
        m_deb = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_cyc = 0;
        for (int k = 0; k < 2; k++) begin
            m_last[k] = -1000;
            m_act[k]  = 1'b0;
        end
        m_fault = 1'b0;
    endfunction

    function automatic void model_edge(input logic [2:0] raw);
        logic [2:0] s;
        logic [2:0] nd;
        logic       fn;
        logic       press;
        int         hoff;
        s = m_hist.pop_front();
        m_hist.push_back(raw);
        nd = m_deb;
        for (int c = 0; c < 3; c++) begin
            if (s[c] != m_deb[c]) begin
                m_run[c]++;
                if (m_run[c] == DC) begin
                    nd[c] = s[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_cyc++;
        fn = nd[1] & nd[2];
        press = nd[0] & ~m_deb[0];
        for (int k = 0; k < 2; k++) begin
            hoff = (k == 0) ? HO : 0;
            if (press && !fn && (m_cyc - m_last[k] > hoff)) begin
                m_act[k]  = 1'b1;
                m_last[k] = m_cyc;
            end else begin
                m_act[k] = 1'b0;
            end
        end
        m_deb = nd;
        m_fault = fn;
    endfunction

    task automatic chk(input string nm, input logic a, input logic e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic cmp_model();
        chk("m_act_a", act_a, m_act[0]);
        chk("m_act_b", act_b, m_act[1]);
        chk("m_up_a", up_a, m_deb[1]);
        chk("m_dn_a", dn_a, m_deb[2]);
        chk("m_flt_a", f_a, m_fault);
        chk("m_up_b", up_b, m_deb[1]);
        chk("m_dn_b", dn_b, m_deb[2]);
        chk("m_flt_b", f_b, m_fault);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge({dn_lim_raw, up_lim_raw, btn_raw});
        #1;
        if (act_a) pa++;
        if (act_b) pb++;
        cmp_model();
    endtask

    task automatic set_raw(input logic b, input logic u, input logic d);
        btn_raw = b;
        up_lim_raw = u;
        dn_lim_raw = d;
    endtask

    typedef struct {
        logic b, u, d;
        int   n;
        logic eu, ed, ef;
        int   epa, epb;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic b, input logic u, input logic d,
                       input int n, input logic eu, input logic ed,
                       input logic ef, input int epa, input int epb);
        vec_t v;
        v.b = b; v.u = u; v.d = d; v.n = n;
        v.eu = eu; v.ed = ed; v.ef = ef;
        v.epa = epa; v.epb = epb;
        tbl.push_back(v);
    endtask

    initial begin
        // Reset with every raw input high.
        rst = 1'b1;
        set_raw(1'b1, 1'b1, 1'b1);
        #1;
        model_reset();
        chk("rst_act", act_a, 1'b0);
        chk("rst_up", up_a, 1'b0);
        chk("rst_dn", dn_a, 1'b0);
        chk("rst_flt", f_a, 1'b0);
        repeat (3) tick();
        chk("rst_held_up", up_a, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("post_rst_e%0d_up", e), up_a, 1'b0);
            chk($sformatf("post_rst_e%0d_flt", e), f_a, 1'b0);
        end
        tick();
        chk("post_rst_e6_up", up_a, 1'b1);
        chk("post_rst_e6_dn", dn_a, 1'b1);
        chk("post_rst_e6_flt", f_a, 1'b1);
        chk("post_rst_e6_act", act_a, 1'b0);
        set_raw(1'b0, 1'b0, 1'b0);
        repeat (20) tick();

        // b u d  n   up dn flt pa pb
        add(0, 0, 0, 10, 0, 0, 0, 0, 0);
        add(1, 0, 0, 30, 0, 0, 0, 1, 1);
        add(0, 0, 0, 30, 0, 0, 0, 0, 0);
        add(1, 0, 0, 3,  0, 0, 0, 0, 0);
        add(0, 0, 0, 12, 0, 0, 0, 0, 0);
        add(0, 1, 0, 3,  0, 0, 0, 0, 0);
        add(0, 0, 0, 12, 0, 0, 0, 0, 0);
        add(0, 1, 0, 4,  0, 0, 0, 0, 0);
        add(0, 0, 0, 3,  1, 0, 0, 0, 0);
        add(0, 0, 0, 10, 0, 0, 0, 0, 0);
        add(0, 0, 1, 10, 0, 1, 0, 0, 0);
        add(0, 1, 1, 10, 1, 1, 1, 0, 0);
        add(1, 1, 1, 10, 1, 1, 1, 0, 0);
        add(0, 1, 1, 10, 1, 1, 1, 0, 0);
        add(0, 0, 1, 10, 0, 1, 0, 0, 0);
        add(1, 0, 1, 10, 0, 1, 0, 1, 1);
        add(0, 0, 0, 20, 0, 0, 0, 0, 0);
        add(1, 1, 1, 10, 1, 1, 1, 0, 0);
        add(0, 1, 1, 10, 1, 1, 1, 0, 0);
        add(1, 0, 1, 10, 0, 1, 0, 1, 1);
        add(0, 0, 0, 30, 0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 1, 1);
        add(0, 0, 0, 5,  0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 0, 1);
        add(0, 0, 0, 5,  0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 1, 1);
        add(0, 0, 0, 30, 0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 1, 1);
        add(0, 0, 0, 6,  0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 0, 1);
        add(0, 0, 0, 30, 0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 1, 1);
        add(0, 0, 0, 7,  0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 1, 1);
        add(0, 0, 0, 30, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            set_raw(tbl[i].b, tbl[i].u, tbl[i].d);
            pa = 0;
            pb = 0;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d_up", i), up_a, tbl[i].eu);
            chk($sformatf("vec%0d_dn", i), dn_a, tbl[i].ed);
            chk($sformatf("vec%0d_flt", i), f_a, tbl[i].ef);
            chk_int($sformatf("vec%0d_pulses_a", i), pa, tbl[i].epa);
            chk_int($sformatf("vec%0d_pulses_b", i), pb, tbl[i].epb);
        end

        // Reset mid-count and mid-holdoff.
        set_raw(1'b1, 1'b1, 1'b0);
        repeat (10) tick();
        set_raw(1'b0, 1'b1, 1'b0);
        repeat (6) tick();
        set_raw(1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        chk("mid_up_before", up_a, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_act", act_a, 1'b0);
        chk("mid_rst_up", up_a, 1'b0);
        chk("mid_rst_dn", dn_a, 1'b0);
        chk("mid_rst_flt", f_a, 1'b0);
        set_raw(1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        btn_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("mid_press_e%0d", e), act_a, (e == 6));
        end
        btn_raw = 1'b0;
        repeat (20) tick();

        // Random stimulus with occasional resets.
        for (int s = 0; s < 400; s++) begin
            set_raw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                cmp_model();
                tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 8)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
